// File: rtl/reg_file_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_cmd_ctrl
// Description : Byte-stream command parser in front of a register file.
//               Write frame : WR_CMD, addr, data_lo, data_hi -> one-cycle WrEn
//               Read frame  : RD_CMD, addr -> one-cycle RdEn, wait for
//                             RdData_Valid (bounded by RD_TIMEOUT), then send
//                             the captured word to the transmitter low byte
//                             first, honouring TX_BUSY.
//               Bad opcodes, out-of-range addresses and read timeouts raise
//               a one-cycle CMD_ERR pulse.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   CLK, RST                 clock, asynchronous active-low reset
//   RX_P_DATA, RX_D_VLD      received byte and its one-cycle strobe
//   WrEn, RdEn               register-file write / read strobes
//   Address, WrData          register-file address and write data
//   RdData, RdData_Valid     register-file read data and its strobe
//   TX_P_DATA, TX_D_VLD      byte to transmitter and its one-cycle strobe
//   TX_BUSY                  transmitter busy
//   CMD_ERR                  one-cycle error pulse
// ============================================================================
module reg_file_cmd_ctrl #(
    parameter int         DATA_WIDTH = 16,
    parameter int         ADDR_WIDTH = 4,
    parameter int         DEPTH      = 8,
    parameter logic [7:0] WR_CMD     = 8'hAA,
    parameter logic [7:0] RD_CMD     = 8'hBB,
    parameter int         RD_TIMEOUT = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [7:0]            RX_P_DATA,
    input  logic                  RX_D_VLD,
    output logic                  WrEn,
    output logic                  RdEn,
    output logic [ADDR_WIDTH-1:0] Address,
    output logic [DATA_WIDTH-1:0] WrData,
    input  logic [DATA_WIDTH-1:0] RdData,
    input  logic                  RdData_Valid,
    output logic [7:0]            TX_P_DATA,
    output logic                  TX_D_VLD,
    input  logic                  TX_BUSY,
    output logic                  CMD_ERR
);

    localparam int                CNT_W    = $clog2(RD_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        WR_ADDR    = 4'd1,
        WR_LO      = 4'd2,
        WR_HI      = 4'd3,
        WR_STB     = 4'd4,
        RD_ADDR    = 4'd5,
        RD_STB     = 4'd6,
        RD_WAIT    = 4'd7,
        TX_LO      = 4'd8,
        TX_LO_WAIT = 4'd9,
        TX_HI      = 4'd10,
        TX_HI_WAIT = 4'd11
    } state_t;

    state_t                  state;
    state_t                  state_nx;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wr_data_q;
    logic [DATA_WIDTH-1:0]   cap;
    logic [CNT_W-1:0]        cnt;
    logic                    cmd_err;
    logic                    tx_guard;

    logic                    err_nx;
    logic                    ld_addr;
    logic                    ld_lo;
    logic                    ld_hi;
    logic                    ld_cap;
    logic                    cnt_clr;
    logic                    cnt_inc;
    logic                    wr_en;
    logic                    rd_en;
    logic                    tx_vld;
    logic                    tx_sel_hi;
    logic                    addr_ok;

    // The whole byte must address an implemented register: any bit above
    // the address field, or a value past the last register, is rejected.
    assign addr_ok = ({24'd0, RX_P_DATA} < 32'(DEPTH)) &&
                     ((RX_P_DATA >> ADDR_WIDTH) == 8'd0);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            addr_q    <= '0;
            wr_data_q <= '0;
            cap       <= '0;
            cnt       <= '0;
            cmd_err   <= 1'b0;
            tx_guard  <= 1'b0;
        end else begin
            state    <= state_nx;
            cmd_err  <= err_nx;
            // High for the cycle right after a TX strobe; the transmitter may
            // not yet have raised TX_BUSY in that cycle, so it is ignored.
            tx_guard <= tx_vld;
            if (ld_addr) addr_q          <= RX_P_DATA[ADDR_WIDTH-1:0];
            if (ld_lo)   wr_data_q[7:0]  <= RX_P_DATA;
            if (ld_hi)   wr_data_q[15:8] <= RX_P_DATA;
            if (ld_cap)  cap             <= RdData;
            if (cnt_clr) begin
                cnt <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nx  = state;
        err_nx    = 1'b0;
        ld_addr   = 1'b0;
        ld_lo     = 1'b0;
        ld_hi     = 1'b0;
        ld_cap    = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        tx_vld    = 1'b0;
        tx_sel_hi = 1'b0;
        case (state)
            IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == WR_CMD) begin
                        state_nx = WR_ADDR;
                    end else if (RX_P_DATA == RD_CMD) begin
                        state_nx = RD_ADDR;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            WR_ADDR: begin
                if (RX_D_VLD) begin
                    if (addr_ok) begin
                        ld_addr  = 1'b1;
                        state_nx = WR_LO;
                    end else begin
                        err_nx   = 1'b1;
                        state_nx = IDLE;
                    end
                end
            end
            WR_LO: begin
                if (RX_D_VLD) begin
                    ld_lo    = 1'b1;
                    state_nx = WR_HI;
                end
            end
            WR_HI: begin
                if (RX_D_VLD) begin
                    ld_hi    = 1'b1;
                    state_nx = WR_STB;
                end
            end
            WR_STB: begin
                wr_en    = 1'b1;
                state_nx = IDLE;
            end
            RD_ADDR: begin
                if (RX_D_VLD) begin
                    if (addr_ok) begin
                        ld_addr  = 1'b1;
                        state_nx = RD_STB;
                    end else begin
                        err_nx   = 1'b1;
                        state_nx = IDLE;
                    end
                end
            end
            RD_STB: begin
                rd_en    = 1'b1;
                cnt_clr  = 1'b1;
                state_nx = RD_WAIT;
            end
            RD_WAIT: begin
                // Valid data wins even on the last allowed cycle.
                if (RdData_Valid) begin
                    ld_cap   = 1'b1;
                    state_nx = TX_LO;
                end else if (cnt == CNT_LAST) begin
                    err_nx   = 1'b1;
                    state_nx = IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            TX_LO: begin
                if (!TX_BUSY) begin
                    tx_vld   = 1'b1;
                    state_nx = TX_LO_WAIT;
                end
            end
            TX_LO_WAIT: begin
                if (!tx_guard && !TX_BUSY) begin
                    state_nx = TX_HI;
                end
            end
            TX_HI: begin
                tx_sel_hi = 1'b1;
                if (!TX_BUSY) begin
                    tx_vld   = 1'b1;
                    state_nx = TX_HI_WAIT;
                end
            end
            TX_HI_WAIT: begin
                tx_sel_hi = 1'b1;
                if (!tx_guard && !TX_BUSY) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign WrEn      = wr_en;
    assign RdEn      = rd_en;
    assign Address   = addr_q;
    assign WrData    = wr_data_q;
    assign TX_D_VLD  = tx_vld;
    assign TX_P_DATA = tx_sel_hi ? cap[15:8] : cap[7:0];
    assign CMD_ERR   = cmd_err;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file_cmd_ctrl
// Description : Self-checking bench for reg_file_cmd_ctrl with a register
//               file model, a transmitter model and a frame-level reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_cmd_ctrl;

    localparam int DW         = 16;
    localparam int AW         = 4;
    localparam int DEPTH      = 8;
    localparam int RD_TIMEOUT = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic [7:0]    RX_P_DATA = 8'd0;
    logic          RX_D_VLD = 1'b0;
    logic          WrEn;
    logic          RdEn;
    logic [AW-1:0] Address;
    logic [DW-1:0] WrData;
    logic [DW-1:0] RdData = '0;
    logic          RdData_Valid = 1'b0;
    logic [7:0]    TX_P_DATA;
    logic          TX_D_VLD;
    logic          TX_BUSY;
    logic          CMD_ERR;

    int total = 0;
    int bad   = 0;

    reg_file_cmd_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH),
        .WR_CMD     (8'hAA),
        .RD_CMD     (8'hBB),
        .RD_TIMEOUT (RD_TIMEOUT)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .RX_P_DATA    (RX_P_DATA),
        .RX_D_VLD     (RX_D_VLD),
        .WrEn         (WrEn),
        .RdEn         (RdEn),
        .Address      (Address),
        .WrData       (WrData),
        .RdData       (RdData),
        .RdData_Valid (RdData_Valid),
        .TX_P_DATA    (TX_P_DATA),
        .TX_D_VLD     (TX_D_VLD),
        .TX_BUSY      (TX_BUSY),
        .CMD_ERR      (CMD_ERR)
    );

    always #5 CLK = ~CLK;

    // ---------------- register file model ----------------
    logic [DW-1:0] rf_mem [16];
    logic [DW-1:0] ref_mem [16];
    bit            rf_load    = 1'b1;
    bit            rf_respond = 1'b1;
    int            rf_delay   = 1;
    int            rd_cd      = 0;
    logic [AW-1:0] rd_addr_q  = '0;

    always @(posedge CLK) begin
        RdData_Valid <= 1'b0;
        RdData       <= DW'($urandom);
        if (rf_load) begin
            for (int i = 0; i < 16; i++) rf_mem[i] <= ref_mem[i];
        end else if (WrEn) begin
            rf_mem[Address] <= WrData;
        end
        if (RdEn && rf_respond) begin
            rd_addr_q <= Address;
            if (rf_delay == 1) begin
                RdData_Valid <= 1'b1;
                RdData       <= rf_mem[Address];
            end else begin
                rd_cd <= rf_delay - 1;
            end
        end else if (rd_cd > 0) begin
            rd_cd <= rd_cd - 1;
            if (rd_cd == 1) begin
                RdData_Valid <= 1'b1;
                RdData       <= rf_mem[rd_addr_q];
            end
        end
    end

    // ---------------- transmitter model ----------------
    int busy_len   = 2;
    bit force_busy = 1'b0;
    int busy_cnt   = 0;
    assign TX_BUSY = force_busy || (busy_cnt > 0);

    always @(posedge CLK) begin
        if (TX_D_VLD)          busy_cnt <= busy_len;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end

    // ---------------- output monitor ----------------
    logic [7:0]       tx_q [$];
    logic [AW+DW-1:0] wr_log [$];
    logic [AW-1:0]    rd_log [$];
    int               err_n     = 0;
    int               viol_busy = 0;
    int               viol_excl = 0;

    always @(negedge CLK) begin
        if (TX_D_VLD) begin
            tx_q.push_back(TX_P_DATA);
            if (TX_BUSY) viol_busy <= viol_busy + 1;
        end
        if (WrEn && RdEn) viol_excl <= viol_excl + 1;
        if (WrEn) wr_log.push_back({Address, WrData});
        if (RdEn) rd_log.push_back(Address);
        if (CMD_ERR) err_n <= err_n + 1;
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs_zero(input string p);
        check({p, "_WrEn"},      32'(WrEn),      32'd0);
        check({p, "_RdEn"},      32'(RdEn),      32'd0);
        check({p, "_Address"},   32'(Address),   32'd0);
        check({p, "_WrData"},    32'(WrData),    32'd0);
        check({p, "_TX_P_DATA"}, 32'(TX_P_DATA), 32'd0);
        check({p, "_TX_D_VLD"},  32'(TX_D_VLD),  32'd0);
        check({p, "_CMD_ERR"},   32'(CMD_ERR),   32'd0);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    logic [7:0] fr [$];

    task automatic send_frame();
        for (int i = 0; i < fr.size(); i++) begin
            tick($urandom_range(0, 2));
            RX_P_DATA = fr[i];
            RX_D_VLD  = 1'b1;
            tick(1);
            RX_D_VLD  = 1'b0;
            RX_P_DATA = 8'($urandom);
        end
    endtask

    // Predicts a frame's outcome from the command rules, sends it, then
    // compares the observed strobes, errors and TX bytes.
    task automatic run_frame(input int delay, input bit respond);
        int            exp_err = 0;
        int            exp_wr  = 0;
        int            exp_rd  = 0;
        logic [7:0]    b0;
        logic [7:0]    b1;
        logic [AW-1:0] ea = '0;
        logic [DW-1:0] ed = '0;
        logic [DW-1:0] word;
        logic [7:0]    etx [$];
        int            err0, wr0, rd0, tx0, n;
        logic [AW+DW-1:0] wr_ev;
        b0 = fr[0];
        b1 = (fr.size() > 1) ? fr[1] : 8'd0;
        if ((b0 == 8'hAA || b0 == 8'hBB) && fr.size() > 1) begin
            if (int'(b1) >= DEPTH) begin
                exp_err = 1;
            end else if (b0 == 8'hAA) begin
                ea = b1[AW-1:0];
                ed = {fr[3], fr[2]};
                exp_wr = 1;
                ref_mem[ea] = ed;
            end else begin
                ea = b1[AW-1:0];
                exp_rd = 1;
                if (respond && delay <= RD_TIMEOUT) begin
                    word = ref_mem[ea];
                    etx.push_back(word[7:0]);
                    etx.push_back(word[15:8]);
                end else begin
                    exp_err = 1;
                end
            end
        end else begin
            exp_err = 1;
        end
        rf_delay   = delay;
        rf_respond = respond;
        err0 = err_n; wr0 = wr_log.size(); rd0 = rd_log.size(); tx0 = tx_q.size();
        send_frame();
        n = 0;
        while (!((err_n - err0 >= exp_err) && (wr_log.size() - wr0 >= exp_wr) &&
                 (rd_log.size() - rd0 >= exp_rd) && (tx_q.size() - tx0 >= etx.size()))
               && n < 100) begin
            tick(1);
            n++;
        end
        check("frame_wait_expired", 32'(n >= 100), 32'd0);
        tick(12);
        check("cmd_err_pulses", 32'(err_n - err0), 32'(exp_err));
        check("wren_pulses", 32'(wr_log.size() - wr0), 32'(exp_wr));
        if (exp_wr == 1 && wr_log.size() > wr0) begin
            wr_ev = wr_log[wr0];
            check("wr_address", 32'(wr_ev[AW+DW-1:DW]), 32'(ea));
            check("wr_data", 32'(wr_ev[DW-1:0]), 32'(ed));
        end
        check("rden_pulses", 32'(rd_log.size() - rd0), 32'(exp_rd));
        if (exp_rd == 1 && rd_log.size() > rd0) check("rd_address", 32'(rd_log[rd0]), 32'(ea));
        check("tx_count", 32'(tx_q.size() - tx0), 32'(etx.size()));
        for (int i = 0; i < etx.size() && tx0 + i < tx_q.size(); i++)
            check("tx_byte", 32'(tx_q[tx0 + i]), 32'(etx[i]));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int err0, wr0, rd0, tx0, n;
        logic [DW-1:0] w;
        logic [7:0] r;

        for (int i = 0; i < 16; i++) ref_mem[i] = DW'($urandom);
        #12;
        check_outputs_zero("reset");
        @(posedge CLK); #1;
        rf_load = 1'b0;
        RST     = 1'b1;
        tick(2);

        // Basic write then read-back
        fr = {8'hAA, 8'h03, 8'h34, 8'h12};
        run_frame(1, 1'b1);
        check("hold_address", 32'(Address), 32'd3);
        check("hold_wrdata", 32'(WrData), 32'h1234);
        fr = {8'hBB, 8'h03};
        run_frame(1, 1'b1);
        check("hold_wrdata_after_read", 32'(WrData), 32'h1234);

        // Error cases
        fr = {8'h55};
        run_frame(1, 1'b1);
        fr = {8'hAA, 8'h09};
        run_frame(1, 1'b1);
        fr = {8'hBB, 8'h02};
        run_frame(1, 1'b0);

        // Boundaries: last address, command-valued data, read latency edges
        fr = {8'hAA, 8'h07, 8'hAA, 8'hBB};
        run_frame(1, 1'b1);
        fr = {8'hBB, 8'h07};
        run_frame(RD_TIMEOUT, 1'b1);
        fr = {8'hBB, 8'h07};
        run_frame(RD_TIMEOUT + 1, 1'b1);
        fr = {8'hAA, 8'h08};
        run_frame(1, 1'b1);
        fr = {8'hBB, 8'h13};
        run_frame(1, 1'b1);

        // Transmitter held busy; a byte arriving during TX is dropped
        force_busy = 1'b1;
        rf_delay = 1; rf_respond = 1'b1;
        err0 = err_n; wr0 = wr_log.size(); rd0 = rd_log.size(); tx0 = tx_q.size();
        fr = {8'hBB, 8'h03};
        send_frame();
        tick(10);
        RX_P_DATA = 8'hAA; RX_D_VLD = 1'b1;
        tick(1);
        RX_D_VLD = 1'b0;
        tick(10);
        check("busy_hold_no_tx", 32'(tx_q.size() - tx0), 32'd0);
        check("busy_rden_pulses", 32'(rd_log.size() - rd0), 32'd1);
        force_busy = 1'b0;
        n = 0;
        while (tx_q.size() - tx0 < 2 && n < 100) begin
            tick(1);
            n++;
        end
        check("busy_release_wait_expired", 32'(n >= 100), 32'd0);
        tick(12);
        w = ref_mem[3];
        if (tx_q.size() - tx0 >= 2) begin
            check("busy_tx_lo", 32'(tx_q[tx0]), 32'(w[7:0]));
            check("busy_tx_hi", 32'(tx_q[tx0 + 1]), 32'(w[15:8]));
        end
        check("busy_no_err", 32'(err_n - err0), 32'd0);
        check("busy_no_wren", 32'(wr_log.size() - wr0), 32'd0);
        fr = {8'hAA, 8'h05, 8'h5A, 8'hC3};
        run_frame(1, 1'b1);

        // Reset in the middle of a write frame
        err0 = err_n; wr0 = wr_log.size();
        fr = {8'hAA, 8'h01, 8'hFF};
        send_frame();
        #3;
        RST = 1'b0;
        #1;
        check_outputs_zero("midreset");
        @(posedge CLK); #1;
        RST = 1'b1;
        tick(6);
        check("midreset_no_wren", 32'(wr_log.size() - wr0), 32'd0);
        check("midreset_no_err", 32'(err_n - err0), 32'd0);
        fr = {8'hFF};
        run_frame(1, 1'b1);
        fr = {8'hEE};
        run_frame(1, 1'b1);

        // Randomised frames against the reference
        for (int k = 0; k < 40; k++) begin
            busy_len = $urandom_range(0, 4);
            case ($urandom_range(0, 5))
                0, 1: begin
                    fr = {8'hAA, 8'($urandom_range(0, DEPTH - 1)), 8'($urandom), 8'($urandom)};
                    if ($urandom_range(0, 3) == 0) fr[2] = 8'hBB;
                    if ($urandom_range(0, 3) == 0) fr[3] = 8'hAA;
                    run_frame(1, 1'b1);
                end
                2, 3: begin
                    fr = {8'hBB, 8'($urandom_range(0, DEPTH - 1))};
                    run_frame($urandom_range(1, RD_TIMEOUT + 1), ($urandom_range(0, 9) != 0));
                end
                4: begin
                    r = 8'($urandom);
                    while (r == 8'hAA || r == 8'hBB) r = 8'($urandom);
                    fr = {r};
                    run_frame(1, 1'b1);
                end
                default: begin
                    fr = {($urandom_range(0, 1) == 1) ? 8'hAA : 8'hBB,
                          8'($urandom_range(DEPTH, 255))};
                    run_frame(1, 1'b1);
                end
            endcase
        end

        check("tx_vld_while_busy", 32'(viol_busy), 32'd0);
        check("wren_rden_overlap", 32'(viol_excl), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
